// File: rtl/radix4_mult_sequencer_pkg.sv
// radix4_mult_pkg: shared FSM state type, digit width and step-count helper for the radix-4 multiplier.
package radix4_mult_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  localparam int DIGIT_W = 2;
  function automatic int steps(input int w);
    return w / 2;
  endfunction
endpackage

// File: rtl/radix4_mult_sequencer_pp_gen.sv
// radix4_pp_gen: combinational radix-4 partial product (0, M, 2M or 3M) of one multiplier digit.
module radix4_pp_gen
  import radix4_mult_pkg::*;
#(
  parameter int WORD_LENGHT = 16
) (
  input  logic [DIGIT_W-1:0]     digit,
  input  logic [WORD_LENGHT-1:0] mcand,
  output logic [WORD_LENGHT+1:0] pp
);
  logic [WORD_LENGHT+1:0] m1, m2;
  assign m1 = {2'b00, mcand};
  assign m2 = {1'b0, mcand, 1'b0};
  assign pp = digit == 2'd0 ? '0 : digit == 2'd1 ? m1 : digit == 2'd2 ? m2 : m1 + m2;
endmodule

// File: rtl/radix4_mult_sequencer.sv
// radix4_mult_sequencer: sequences an external 2-bit-per-step shifter and accumulates the radix-4 product.
module radix4_mult_sequencer
  import radix4_mult_pkg::*;
#(
  parameter int WORD_LENGHT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGHT-1:0]   multiplicand,
  input  logic [DIGIT_W-1:0]       mult_bits,
  output logic                     shift_enable,
  output logic                     synch_reset,
  output logic                     busy,
  output logic                     done,
  output logic [2*WORD_LENGHT-1:0] product
);
  localparam int STEPS = steps(WORD_LENGHT);
  localparam int SW = $clog2(STEPS);
  localparam int PW = 2 * WORD_LENGHT;
  state_t                 state_q, state_d;
  logic [SW-1:0]          step_q, step_d;
  logic [WORD_LENGHT-1:0] mcand_q, mcand_d;
  logic [PW-1:0]          acc_q, acc_d, product_q, product_d;
  logic [WORD_LENGHT+1:0] pp;
  logic [PW-1:0]          pp_ext, acc_sum;
  logic                   last, accept;
  radix4_pp_gen #(.WORD_LENGHT(WORD_LENGHT)) u_pp (
    .digit(mult_bits),
    .mcand(mcand_q),
    .pp   (pp)
  );
  assign last    = step_q == SW'(STEPS - 1);
  assign accept  = state_q == IDLE && start;
  assign pp_ext  = {{(WORD_LENGHT - 2){1'b0}}, pp} << {step_q, 1'b0};
  assign acc_sum = acc_q + pp_ext;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      step_q    <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? (start ? CLEAR : IDLE) :
              state_q == CLEAR ? RUN :
              state_q == RUN   ? (last ? DONE : RUN) : IDLE;
  end
  // The product register captures the final sum on the RUN->DONE edge so it is valid alongside done.
  always_comb begin
    mcand_d   = accept ? multiplicand : mcand_q;
    acc_d     = accept ? '0 : state_q == RUN ? acc_sum : acc_q;
    step_d    = state_q == CLEAR ? '0 : state_q == RUN ? step_q + SW'(1) : step_q;
    product_d = state_q == RUN && last ? acc_sum : product_q;
  end
  always_comb begin
    synch_reset  = state_q == CLEAR;
    shift_enable = state_q == RUN;
    busy         = state_q == CLEAR || state_q == RUN;
    done         = state_q == DONE;
  end
  assign product = product_q;
endmodule

// File: tb/tb_radix4_mult_sequencer.sv
// tb_radix4_mult_sequencer: drives the sequencer with a behavioural 2-bit shifter and scoreboards products.
module tb_radix4_mult_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] operand = '0;
  logic [1:0]  mult_bits;
  logic        shift_enable, synch_reset, busy, done;
  logic [31:0] product;
  logic [3:0]  cnt;
  logic [15:0] sh;
  logic [31:0] sb[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (synch_reset) cnt <= '0;
    else if (shift_enable) cnt <= cnt + 4'd1;
  end
  assign sh = operand >> {cnt, 1'b0};
  assign mult_bits = sh[1:0];

  radix4_mult_sequencer #(.WORD_LENGHT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .multiplicand(multiplicand),
    .mult_bits   (mult_bits),
    .shift_enable(shift_enable),
    .synch_reset (synch_reset),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle c is the period following edge c-1, where edge 0 samples start.
  task automatic run(input logic [15:0] mc, input logic [15:0] op, input bit restart);
    @(negedge clk);
    multiplicand = mc;
    operand = op;
    start = 1'b1;
    sb.push_back(32'(mc) * 32'(op));
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = restart && c >= 2 && c <= 5;
      check($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 9));
      check($sformatf("done_c%0d", c), 32'(done), 32'(c == 10));
      check($sformatf("sreset_c%0d", c), 32'(synch_reset), 32'(c == 1));
      check($sformatf("shen_c%0d", c), 32'(shift_enable), 32'(c >= 2 && c <= 9));
      if (c == 10) check("product", product, sb.pop_front());
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sreset", 32'(synch_reset), 32'd0);
    check("rst_shen", 32'(shift_enable), 32'd0);
    check("rst_product", product, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    run(16'd5, 16'd3, 1'b0);
    run(16'hFFFF, 16'hFFFF, 1'b0);
    run(16'h1234, 16'h0000, 1'b0);
    run(16'h0000, 16'hABCD, 1'b0);
    run(16'h00A5, 16'h3C96, 1'b1);
    run(16'h00FF, 16'h0100, 1'b0);
    @(negedge clk);
    check("idle_after_done", 32'(busy), 32'd0);
    multiplicand = 16'h1234;
    operand = 16'h5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_pre_busy", 32'(shift_enable), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_shen", 32'(shift_enable), 32'd0);
    check("abort_product", product, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run(16'd7, 16'd9, 1'b0);
    run(16'($urandom), 16'($urandom), 1'b0);
    repeat (3) @(negedge clk);
    check("no_extra_done", 32'(done), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
